forwarding_hazard_unit: RTL and testbench



---
 rtl/mips_pipe_pkg.sv | 27 ++
 rtl/fwd_select.sv | 28 ++
 rtl/forwarding_hazard_unit.sv | 142 ++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the forwarding/hazard unit.
// shadow_t describes one in-flight instruction as seen by the forwarding logic.
package mips_pipe_pkg;

    // Widest register index the shadow can carry (LEN up to 256)
    localparam int RD_MAX_W = 8;

    typedef logic [RD_MAX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        logic     wr;
        reg_idx_t rd;
        logic     load;
    } shadow_t;

    // Operand select encoding: 0 = register file, k = k stages after EX
    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    // True when the entry is a live writer of a non-zero register r
    function automatic logic writes_reg(shadow_t e, reg_idx_t r);
        return e.valid & e.wr & (e.rd == r) & (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand priority matcher: picks the youngest post-EX producer of src.
// Loads are only forwardable once they are more than LOAD_LAT stages past EX.
module fwd_select
    import mips_pipe_pkg::*;
#(
    parameter int STAGES   = 2,
    parameter int LOAD_LAT = 1,
    parameter int SW       = $clog2(STAGES + 1)
) (
    input  logic                 ex_valid,
    input  shadow_t [STAGES:1]   older,
    input  reg_idx_t             src,
    output logic    [SW-1:0]     sel
);

    // Scan oldest to youngest so the youngest matching stage is written last
    always_comb begin
        sel = SW'(FWD_RF);
        if (ex_valid) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (writes_reg(older[k], src) && (!older[k].load || (k > LOAD_LAT))) begin
                    sel = SW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use hazard unit.
// Keeps a shadow of the EX instruction and STAGES later instructions, drives
// the EX operand selects, and raises stall/bubble for loads still in flight.
// Optional feature: define FWD_STALL_STATS_EN to add a saturating stall_count.
module forwarding_hazard_unit
    import mips_pipe_pkg::*;
#(
    parameter int LEN      = 32,
    parameter int NB       = $clog2(LEN),
    parameter int STAGES   = 2,
    parameter int LOAD_LAT = 1,
    parameter int SW       = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [NB-1:0] id_rs,
    input  logic [NB-1:0] id_rt,
    input  logic [NB-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          hold,
    input  logic          flush,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b,
    output logic          stall,
    output logic          bubble
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [31:0]   stall_count
`endif
);

    if (STAGES < 2 || STAGES > 7) begin : g_bad_stages
        $error("forwarding_hazard_unit: STAGES must be 2..7");
    end
    if (LOAD_LAT < 1 || STAGES < LOAD_LAT + 1) begin : g_bad_load_lat
        $error("forwarding_hazard_unit: need 1 <= LOAD_LAT <= STAGES-1");
    end
    if (NB > RD_MAX_W) begin : g_bad_nb
        $error("forwarding_hazard_unit: register index wider than shadow field");
    end

    // Valid bits are the only state that needs a reset; the rest is qualified by them
    logic [STAGES:0] sh_vld;
    logic [STAGES:0] sh_wr;
    logic [STAGES:0] sh_load;
    reg_idx_t        sh_rd [STAGES:0];
    reg_idx_t        ex_rs;
    reg_idx_t        ex_rt;
    shadow_t [STAGES:0] sh;

    reg_idx_t id_rs_x;
    reg_idx_t id_rt_x;
    logic     hazard;
    logic     issue;

    assign id_rs_x = reg_idx_t'(id_rs);
    assign id_rt_x = reg_idx_t'(id_rt);

    // Gather the split shadow registers into entry records
    always_comb begin
        for (int k = 0; k <= STAGES; k++) begin
            sh[k].valid = sh_vld[k];
            sh[k].wr    = sh_wr[k];
            sh[k].rd    = sh_rd[k];
            sh[k].load  = sh_load[k];
        end
    end

    // A load within the first LOAD_LAT entries cannot yet supply the ID operands
    always_comb begin
        hazard = 1'b0;
        for (int j = 0; j < LOAD_LAT; j++) begin
            if (sh[j].load && (writes_reg(sh[j], id_rs_x) || writes_reg(sh[j], id_rt_x))) begin
                hazard = 1'b1;
            end
        end
    end

    // Flush outranks the hazard; hold suppresses both controls
    assign stall  = ~hold & id_valid & ~flush & hazard;
    assign bubble = ~hold & (stall | flush);
    assign issue  = id_valid & ~stall & ~flush;

    // Shift valid bits; a stalled or flushed ID enters EX as a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_vld <= '0;
        end else if (!hold) begin
            sh_vld <= {sh_vld[STAGES-1:0], issue};
        end
    end

    // Shift instruction fields alongside the valid bits
    always_ff @(posedge clk) begin
        if (!hold) begin
            sh_wr    <= {sh_wr[STAGES-1:0], id_reg_write};
            sh_load  <= {sh_load[STAGES-1:0], id_mem_read};
            sh_rd[0] <= reg_idx_t'(id_rd);
            for (int k = 1; k <= STAGES; k++) begin
                sh_rd[k] <= sh_rd[k-1];
            end
            ex_rs <= id_rs_x;
            ex_rt <= id_rt_x;
        end
    end

    fwd_select #(
        .STAGES   (STAGES),
        .LOAD_LAT (LOAD_LAT),
        .SW       (SW)
    ) u_fwd_a (
        .ex_valid (sh_vld[0]),
        .older    (sh[STAGES:1]),
        .src      (ex_rs),
        .sel      (fwd_a)
    );

    fwd_select #(
        .STAGES   (STAGES),
        .LOAD_LAT (LOAD_LAT),
        .SW       (SW)
    ) u_fwd_b (
        .ex_valid (sh_vld[0]),
        .older    (sh[STAGES:1]),
        .src      (ex_rt),
        .sel      (fwd_b)
    );

`ifdef FWD_STALL_STATS_EN
    // Count stalled cycles, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: one default instance (STAGES=2, LOAD_LAT=1)
// and one deeper instance (STAGES=3, LOAD_LAT=2) fed the same ID stream.
// The reference keeps a queue of in-flight instructions per instance.
module tb_forwarding_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_reg_write, id_mem_read, hold, flush;

    logic [1:0] a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
    logic       a_stall, a_bubble, b_stall, b_bubble;
`ifdef FWD_STALL_STATS_EN
    logic [31:0] a_cnt, b_cnt;
`endif

    forwarding_hazard_unit dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .hold         (hold),
        .flush        (flush),
        .fwd_a        (a_fwd_a),
        .fwd_b        (a_fwd_b),
        .stall        (a_stall),
        .bubble       (a_bubble)
`ifdef FWD_STALL_STATS_EN
        ,
        .stall_count  (a_cnt)
`endif
    );

    forwarding_hazard_unit #(
        .STAGES   (3),
        .LOAD_LAT (2)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .hold         (hold),
        .flush        (flush),
        .fwd_a        (b_fwd_a),
        .fwd_b        (b_fwd_b),
        .stall        (b_stall),
        .bubble       (b_bubble)
`ifdef FWD_STALL_STATS_EN
        ,
        .stall_count  (b_cnt)
`endif
    );

    typedef struct {
        bit valid;
        bit wr;
        bit load;
        int rd;
        int rs;
        int rt;
    } slot_t;

    // pipe[0] is the instruction in EX, pipe[k] is k stages later
    slot_t pipe_a[$];
    slot_t pipe_b[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int m_fwd(slot_t p[$], int s, int l, int src);
        if (!p[0].valid) return 0;
        for (int k = 1; k <= s; k++) begin
            if (p[k].valid && p[k].wr && p[k].rd == src && src != 0 && (!p[k].load || k > l))
                return k;
        end
        return 0;
    endfunction

    function automatic bit m_stall(slot_t p[$], int l);
        if (hold || !id_valid || flush) return 1'b0;
        for (int j = 0; j < l; j++) begin
            if (p[j].valid && p[j].wr && p[j].load && p[j].rd != 0 &&
                (p[j].rd == int'(id_rs) || p[j].rd == int'(id_rt)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [5:0] m_vec(slot_t p[$], int s, int l);
        int fa, fb;
        bit st;
        fa = m_fwd(p, s, l, p[0].rs);
        fb = m_fwd(p, s, l, p[0].rt);
        st = m_stall(p, l);
        return {2'(fa), 2'(fb), logic'(st), logic'(!hold && (st || flush))};
    endfunction

    function automatic slot_t new_slot(bit st);
        slot_t s;
        s.valid = id_valid && !st && !flush;
        s.wr    = id_reg_write;
        s.load  = id_mem_read;
        s.rd    = int'(id_rd);
        s.rs    = int'(id_rs);
        s.rt    = int'(id_rt);
        return s;
    endfunction

    task automatic model_reset();
        slot_t e;
        e = '{valid: 1'b0, wr: 1'b0, load: 1'b0, rd: 0, rs: 0, rt: 0};
        pipe_a.delete();
        pipe_b.delete();
        repeat (3) pipe_a.push_back(e);
        repeat (4) pipe_b.push_back(e);
    endtask

    task automatic set_id(bit v, int rs, int rt, int rd, bit wr, bit ld);
        id_valid     = v;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_rd        = 5'(rd);
        id_reg_write = wr;
        id_mem_read  = ld;
    endtask

    task automatic set_idle();
        set_id(0, 0, 0, 0, 0, 0);
        hold  = 1'b0;
        flush = 1'b0;
    endtask

    // Advance the reference with the pre-edge inputs, then cross one clock
    task automatic tick();
        bit sa, sb;
        sa = m_stall(pipe_a, 1);
        sb = m_stall(pipe_b, 2);
        if (!hold) begin
            void'(pipe_a.pop_back());
            pipe_a.push_front(new_slot(sa));
            void'(pipe_b.pop_back());
            pipe_b.push_front(new_slot(sb));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        set_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        set_id(1, 3, 5, 7, 1, 1);
        #1;
        n_cmp++;
        if ({a_fwd_a, a_fwd_b, a_stall, a_bubble} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_a: got %b expected 000000", {a_fwd_a, a_fwd_b, a_stall, a_bubble});
        end
        n_cmp++;
        if ({b_fwd_a, b_fwd_b, b_stall, b_bubble} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_b: got %b expected 000000", {b_fwd_a, b_fwd_b, b_stall, b_bubble});
        end
`ifdef FWD_STALL_STATS_EN
        n_cmp++;
        if (a_cnt !== 32'd0 || b_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d/%0d expected 0/0", a_cnt, b_cnt);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({a_stall, a_bubble, b_stall, b_bubble} !== 4'd0) begin
            n_err++;
            $display("FAIL post_reset_ctrl: got %b expected 0000", {a_stall, a_bubble, b_stall, b_bubble});
        end
        set_idle();
    endtask

`ifdef FWD_STALL_STATS_EN
    task automatic test_stats();
        drain();
        repeat (2) begin
            set_id(1, 1, 2, 5, 1, 1);
            tick();
            set_id(1, 6, 5, 7, 1, 0);
            repeat (3) tick();
            drain();
        end
        #1;
        n_cmp++;
        if (b_cnt !== 32'd4) begin
            n_err++;
            $display("FAIL stats_b: got %0d expected 4", b_cnt);
        end
        n_cmp++;
        if (a_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL stats_a: got %0d expected 2", a_cnt);
        end
    endtask
`endif

    task automatic test_youngest();
        drain();
        set_id(1, 1, 2, 3, 1, 0); tick();
        set_id(1, 1, 2, 3, 1, 0); tick();
        set_id(1, 3, 7, 4, 1, 0); tick();
        set_idle();
        #1;
        n_cmp++;
        if (a_fwd_a !== 2'd1) begin
            n_err++;
            $display("FAIL youngest_a: got %0d expected 1", a_fwd_a);
        end
        n_cmp++;
        if (b_fwd_a !== 2'd1) begin
            n_err++;
            $display("FAIL youngest_b: got %0d expected 1", b_fwd_a);
        end
        n_cmp++;
        if (a_fwd_b !== 2'd0) begin
            n_err++;
            $display("FAIL youngest_other_a: got %0d expected 0", a_fwd_b);
        end
        drain();
        set_id(1, 1, 2, 3, 1, 0); tick();
        set_idle(); tick();
        set_id(1, 9, 3, 4, 1, 0); tick();
        set_idle();
        #1;
        n_cmp++;
        if (a_fwd_b !== 2'd2 || a_fwd_a !== 2'd0) begin
            n_err++;
            $display("FAIL memwb_a: got %0d/%0d expected 0/2", a_fwd_a, a_fwd_b);
        end
        n_cmp++;
        if (b_fwd_b !== 2'd2) begin
            n_err++;
            $display("FAIL memwb_b: got %0d expected 2", b_fwd_b);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1, 1, 2, 5, 1, 1);
        #1;
        n_cmp++;
        if (a_stall !== 1'b0) begin
            n_err++;
            $display("FAIL lu_issue: got %b expected 0", a_stall);
        end
        tick();
        set_id(1, 6, 5, 7, 1, 0);
        #1;
        n_cmp++;
        if ({a_stall, a_bubble, b_stall} !== 3'b111) begin
            n_err++;
            $display("FAIL lu_first: got %b expected 111", {a_stall, a_bubble, b_stall});
        end
        tick();
        #1;
        n_cmp++;
        if ({a_stall, b_stall, b_bubble} !== 3'b011) begin
            n_err++;
            $display("FAIL lu_second: got %b expected 011", {a_stall, b_stall, b_bubble});
        end
        tick();
        #1;
        n_cmp++;
        if (a_fwd_b !== 2'd2 || b_stall !== 1'b0) begin
            n_err++;
            $display("FAIL lu_fwd_a: got fwd_b=%0d stall_b=%b expected 2/0", a_fwd_b, b_stall);
        end
        tick();
        set_idle();
        #1;
        n_cmp++;
        if (b_fwd_b !== 2'd3) begin
            n_err++;
            $display("FAIL lu_fwd_b: got %0d expected 3", b_fwd_b);
        end
    endtask

    task automatic test_reg0();
        drain();
        set_id(1, 1, 2, 0, 1, 0); tick();
        set_id(1, 1, 2, 0, 1, 1); tick();
        set_id(1, 0, 0, 6, 1, 0);
        #1;
        n_cmp++;
        if (a_stall !== 1'b0 || b_stall !== 1'b0) begin
            n_err++;
            $display("FAIL r0_stall: got %b/%b expected 0/0", a_stall, b_stall);
        end
        tick();
        set_idle();
        #1;
        n_cmp++;
        if ({a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b} !== 8'd0) begin
            n_err++;
            $display("FAIL r0_fwd: got %b expected 00000000", {a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b});
        end
    endtask

    task automatic test_hold();
        drain();
        set_id(1, 1, 2, 5, 1, 1); tick();
        set_id(1, 5, 8, 9, 1, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({a_stall, a_bubble, b_stall, b_bubble} !== 4'd0) begin
                n_err++;
                $display("FAIL hold_%0d: got %b expected 0000", i, {a_stall, a_bubble, b_stall, b_bubble});
            end
            tick();
        end
        hold = 1'b0;
        #1;
        n_cmp++;
        if ({a_stall, b_stall} !== 2'b11) begin
            n_err++;
            $display("FAIL hold_resume: got %b expected 11", {a_stall, b_stall});
        end
        tick();
        #1;
        n_cmp++;
        if ({a_stall, b_stall} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_remaining: got %b expected 01", {a_stall, b_stall});
        end
        tick();
        set_idle();
    endtask

    task automatic test_flush();
        drain();
        set_id(1, 1, 2, 5, 1, 1); tick();
        set_id(1, 5, 5, 9, 1, 0);
        flush = 1'b1;
        #1;
        n_cmp++;
        if ({a_stall, a_bubble, b_stall, b_bubble} !== 4'b0101) begin
            n_err++;
            $display("FAIL flush_hazard: got %b expected 0101", {a_stall, a_bubble, b_stall, b_bubble});
        end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++;
        if ({a_stall, b_stall} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_after: got %b expected 01", {a_stall, b_stall});
        end
        tick();
        set_idle();
    endtask

    task automatic test_random();
        logic [5:0] ea, eb;
        drain();
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            #1;
            ea = m_vec(pipe_a, 2, 1);
            eb = m_vec(pipe_b, 3, 2);
            n_cmp++;
            if ({a_fwd_a, a_fwd_b, a_stall, a_bubble} !== ea) begin
                n_err++;
                $display("FAIL rand_a[%0d]: got %b expected %b", i, {a_fwd_a, a_fwd_b, a_stall, a_bubble}, ea);
            end
            n_cmp++;
            if ({b_fwd_a, b_fwd_b, b_stall, b_bubble} !== eb) begin
                n_err++;
                $display("FAIL rand_b[%0d]: got %b expected %b", i, {b_fwd_a, b_fwd_b, b_stall, b_bubble}, eb);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_id(1, 1, 2, 5, 1, 1); tick();
        set_id(1, 6, 5, 7, 1, 0);
        #1;
        n_cmp++;
        if (b_stall !== 1'b1) begin
            n_err++;
            $display("FAIL mid_stall_pre: got %b expected 1", b_stall);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_stall, b_stall} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_stall_reset: got %b expected 00", {a_stall, b_stall});
        end
`ifdef FWD_STALL_STATS_EN
        n_cmp++;
        if (a_cnt !== 32'd0 || b_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL mid_stall_count: got %0d/%0d expected 0/0", a_cnt, b_cnt);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_idle();
    endtask

    initial begin
        test_reset();
`ifdef FWD_STALL_STATS_EN
        test_stats();
`endif
        test_youngest();
        test_load_use();
        test_reg0();
        test_hold();
        test_flush();
        test_random();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
